wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_arb_watchdog.sv | 44 ++++
 rtl/wb_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone round-robin arbiter.
// Holds the arbiter state encoding and the master index constants.
// No logic; imported by wb_rr_arbiter and wb_arb_watchdog.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // On a simultaneous request the master that did not own the bus last wins.
    function automatic logic tie_winner(input logic last_gnt);
        return ~last_gnt;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Ack watchdog for the granted master: counts cycles a strobe waits for s_ack.
// Latency: expire is combinational from the registered count (fires on the cycle count==TIMEOUT).
// Ports: active (bus granted), stb (granted strobe), ack (slave ack) -> expire pulse, timeout_cnt.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       stb,
    input  logic       ack,
    output logic       expire,
    output logic [7:0] timeout_cnt
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam bit ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] cnt;

    // An ack in the same cycle as the limit wins, so expire requires !ack.
    assign expire = ENABLED && active && stb && !ack && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            timeout_cnt <= 8'd0;
        end else begin
            // Cleared while idle so a fresh grant always starts from zero.
            if (!ENABLED || !active || ack || expire) begin
                cnt <= '0;
            end else if (stb) begin
                cnt <= cnt + 1'b1;
            end
            if (expire && (timeout_cnt != 8'hFF)) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter onto one shared slave, with ack watchdog.
// Latency: grant registered one cycle after cyc&stb; while granted, s_* follows the owner combinationally.
// Ports: m0 (data bus), m1 (instruction bus) request/response; s_* shared slave; timeout_cnt error count.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel,
    input  logic            m0_we,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack,
    output logic            m0_err,

    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel,
    input  logic            m1_we,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack,
    output logic            m1_err,

    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel,
    output logic            s_we,
    output logic            s_cyc,
    output logic            s_stb,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack,

    output logic [7:0]      timeout_cnt
);

    arb_state_t state;
    logic       last_gnt;
    logic       req0;
    logic       req1;
    logic       gnt_stb;
    logic       expire;

    assign req0 = m0_cyc & m0_stb;
    assign req1 = m1_cyc & m1_stb;

    // Grant is held for as long as the owner keeps cyc high (locked cycles);
    // release always passes through IDLE so the other master gets a look-in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= M1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
                        state <= (tie_winner(last_gnt) == M0) ? GNT0 : GNT1;
                    end else if (req0) begin
                        state <= GNT0;
                    end else if (req1) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc) begin
                        state    <= IDLE;
                        last_gnt <= M0;
                    end
                end
                GNT1: begin
                    if (!m1_cyc) begin
                        state    <= IDLE;
                        last_gnt <= M1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_stb = ((state == GNT0) && m0_stb) || ((state == GNT1) && m1_stb);

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .active      (state != IDLE),
        .stb         (gnt_stb),
        .ack         (s_ack),
        .expire      (expire),
        .timeout_cnt (timeout_cnt)
    );

    // Read data is broadcast; only the ack/err strobes are steered.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        s_adr   = '0;
        s_dat_o = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        case (state)
            GNT0: begin
                s_adr   = m0_adr;
                s_dat_o = m0_dat_i;
                s_sel   = m0_sel;
                s_we    = m0_we;
                // The expiring cycle aborts the bus cycle toward the slave.
                s_cyc   = m0_cyc & ~expire;
                s_stb   = m0_stb & ~expire;
                // An ack with no strobe outstanding is stale and dropped.
                m0_ack  = m0_stb & s_ack;
                m0_err  = expire;
            end
            GNT1: begin
                s_adr   = m1_adr;
                s_dat_o = m1_dat_i;
                s_sel   = m1_sel;
                s_we    = m1_we;
                s_cyc   = m1_cyc & ~expire;
                s_stb   = m1_stb & ~expire;
                m1_ack  = m1_stb & s_ack;
                m1_err  = expire;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] m0_adr,   m1_adr,   s_adr;
    logic [DW-1:0] m0_dat_i, m1_dat_i, s_dat_o;
    logic [SW-1:0] m0_sel,   m1_sel,   s_sel;
    logic          m0_we,    m1_we,    s_we;
    logic          m0_cyc,   m1_cyc,   s_cyc;
    logic          m0_stb,   m1_stb,   s_stb;
    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_i;
    logic          m0_ack,   m1_ack,   s_ack;
    logic          m0_err,   m1_err;
    logic [7:0]    timeout_cnt;

    wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_adr(m0_adr), .m0_dat_i(m0_dat_i), .m0_sel(m0_sel), .m0_we(m0_we),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat_i(m1_dat_i), .m1_sel(m1_sel), .m1_we(m1_we),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel), .s_we(s_we),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_dat_i(s_dat_i), .s_ack(s_ack),
        .timeout_cnt(timeout_cnt)
    );

    // Reference model: who owns the bus (-1 = nobody), who owned it last,
    // how long the owner's strobe has waited, and how many timeouts occurred.
    int owner    = -1;
    int last_own = 1;
    int waited   = 0;
    int n_timeouts = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic own_stb();
        if (owner == 0) return m0_stb;
        if (owner == 1) return m1_stb;
        return 1'b0;
    endfunction

    function automatic logic own_cyc();
        if (owner == 0) return m0_cyc;
        if (owner == 1) return m1_cyc;
        return 1'b0;
    endfunction

    // Owner's strobe has waited the full budget and the slave is still silent.
    function automatic logic gives_up();
        return (owner >= 0) && (TO > 0) && own_stb() && !s_ack && (waited == TO);
    endfunction

    // Compare every output against the model for the current cycle.
    task automatic eval();
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic          e_we;
        logic          hit;
        #2;
        e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0;
        if (owner == 0) begin
            e_adr = m0_adr; e_dat = m0_dat_i; e_sel = m0_sel; e_we = m0_we;
        end else if (owner == 1) begin
            e_adr = m1_adr; e_dat = m1_dat_i; e_sel = m1_sel; e_we = m1_we;
        end
        hit = gives_up();
        chk("s_adr",   s_adr,   e_adr);
        chk("s_dat_o", s_dat_o, e_dat);
        chk("s_sel",   s_sel,   e_sel);
        chk("s_we",    s_we,    e_we);
        chk("s_cyc",   s_cyc,   own_cyc() && !hit);
        chk("s_stb",   s_stb,   own_stb() && !hit);
        chk("m0_dat_o", m0_dat_o, s_dat_i);
        chk("m1_dat_o", m1_dat_o, s_dat_i);
        chk("m0_ack",  m0_ack,  (owner == 0) && own_stb() && s_ack);
        chk("m1_ack",  m1_ack,  (owner == 1) && own_stb() && s_ack);
        chk("m0_err",  m0_err,  (owner == 0) && hit);
        chk("m1_err",  m1_err,  (owner == 1) && hit);
        chk("timeout_cnt", timeout_cnt, n_timeouts);
    endtask

    // Advance one clock and move the model forward using the sampled inputs.
    task automatic tick();
        logic hit;
        logic r0, r1;
        @(posedge clk);
        hit = gives_up();
        r0 = m0_cyc && m0_stb;
        r1 = m1_cyc && m1_stb;
        if (reset) begin
            owner = -1; last_own = 1; waited = 0; n_timeouts = 0;
        end else if (owner < 0) begin
            waited = 0;
            if (r0 && r1)  owner = 1 - last_own;
            else if (r0)   owner = 0;
            else if (r1)   owner = 1;
        end else begin
            if (hit && n_timeouts < 255) n_timeouts++;
            if (hit || s_ack)  waited = 0;
            else if (own_stb()) waited++;
            if (!own_cyc()) begin
                last_own = owner;
                owner = -1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        m0_adr = '0; m0_dat_i = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat_i = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_dat_i = '0; s_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        eval();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        eval();
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_tcnt", timeout_cnt, 0);
        tick();
        reset = 1'b0;

        // m1 single read, slave answers two cycles after seeing the strobe.
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h100; m1_sel = 4'hF;
        eval(); chk("r29_idle_stb", s_stb, 0); tick();
        eval(); chk("r29_gnt_stb", s_stb, 1); chk("r29_adr", s_adr, 32'h100); tick();
        eval(); tick();
        s_ack = 1; s_dat_i = 32'hDEADBEEF;
        eval();
        chk("r29_m1_ack", m1_ack, 1);
        chk("r29_m1_dat", m1_dat_o, 32'hDEADBEEF);
        chk("r29_m0_ack", m0_ack, 0);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        eval(); tick();
        eval(); chk("r29_back_idle", s_adr, 0); tick();

        // Simultaneous requests: m0 first after reset, then m1.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h200;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
        eval(); tick();
        eval(); chk("r30_first_m0", s_adr, 32'h200);
        s_ack = 1;
        eval(); chk("r30_m0_ack", m0_ack, 1); chk("r30_m1_noack", m1_ack, 0); tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        eval(); tick();
        m0_cyc = 1; m0_stb = 1;
        eval(); chk("r30_idle_gap", s_cyc, 0); tick();
        eval(); chk("r30_second_m1", s_adr, 32'h300); tick();
        idle_inputs(); eval(); tick(); eval(); tick();

        // m0 locks the bus across three strobes while m1 waits.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h500;
        eval(); tick();
        for (int k = 0; k < 3; k++) begin
            m0_stb = 1; s_ack = 1;
            eval(); chk("r31_m0_ack", m0_ack, 1); chk("r31_m1_wait", m1_ack, 0); tick();
            m0_stb = 0; s_ack = 0;
            eval(); chk("r31_locked", s_adr, 32'h400); tick();
        end
        m0_cyc = 0;
        eval(); tick();
        eval(); chk("r31_gap", s_cyc, 0); tick();
        eval(); chk("r31_m1_adr", s_adr, 32'h500); chk("r31_m1_stb", s_stb, 1); tick();
        idle_inputs(); eval(); tick(); eval(); tick();

        // Watchdog: silent slave, then an ack exactly on the limit cycle.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h600;
        eval(); tick();
        for (int k = 0; k < TO; k++) begin
            eval(); chk("r32_no_err_yet", m0_err, 0); tick();
        end
        eval();
        chk("r32_err", m0_err, 1); chk("r32_stb_cut", s_stb, 0); chk("r32_cyc_cut", s_cyc, 0);
        tick();
        eval(); chk("r32_err_1cyc", m0_err, 0); chk("r32_tcnt", timeout_cnt, 1); tick();
        idle_inputs(); eval(); tick(); eval(); tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h640;
        eval(); tick();
        for (int k = 0; k < TO; k++) begin
            eval(); tick();
        end
        s_ack = 1;
        eval(); chk("r32_ack_wins", m0_ack, 1); chk("r32_ack_noerr", m0_err, 0); tick();
        idle_inputs(); eval(); tick(); eval(); tick();

        // Reset while m1 has a strobe outstanding.
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h700;
        eval(); tick();
        eval(); chk("r33_pending", s_stb, 1); tick();
        reset = 1;
        eval(); tick();
        reset = 0; s_ack = 1;
        eval(); chk("r33_s_cyc", s_cyc, 0); chk("r33_m1_ack", m1_ack, 0); tick();
        idle_inputs(); eval(); tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) m0_cyc = !m0_cyc;
            if ($urandom_range(0, 7) == 0) m1_cyc = !m1_cyc;
            m0_stb = (m0_cyc && ($urandom_range(0, 3) != 0)) || ($urandom_range(0, 31) == 0);
            m1_stb = (m1_cyc && ($urandom_range(0, 3) != 0)) || ($urandom_range(0, 31) == 0);
            m0_adr = $urandom; m0_dat_i = $urandom; m0_sel = SW'($urandom); m0_we = 1'($urandom);
            m1_adr = $urandom; m1_dat_i = $urandom; m1_sel = SW'($urandom); m1_we = 1'($urandom);
            s_ack   = ($urandom_range(0, 3) == 0);
            s_dat_i = $urandom;
            reset   = ($urandom_range(0, 199) == 0);
            eval();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
